// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
//   Delivers an iNES ROM image to the game loader byte interface.
//   Two byte sources compete for the load: src0 is the embedded BRAM image
//   streamer and src1 is the external UART/SD loader. src1 wins when both
//   request. The sequencer checks the 16-byte iNES header and derives the
//   total image length from it. It spaces the output strobes GAP_CYCLES
//   apart, and reports done/error to the system controller.
//
// Parameters
//   GAP_CYCLES  idle cycles between odata_clk pulses (>= 1)
//   MAX_SIZE    largest accepted image in bytes, header included
//   TIMEOUT     ready-without-valid cycles tolerated before aborting
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   start                   one-cycle pulse, starts a load from IDLE/DONE/ERROR
//   srcN_req/data/valid     source N image request and byte stream
//   srcN_ready              byte accepted from source N this cycle
//   downloading             loader enable, high while a load is running
//   odata, odata_clk        byte to loader and its one-cycle strobe
//   done, error, err_code   sticky completion / abort status
//                           (err_code: 0 no source, 1 bad magic, 2 oversize, 3 timeout)
//   active_src              granted source
//   checksum                (only with LOAD_CHECKSUM_EN) mod-256 sum of strobed bytes
//
// Optional feature macro: LOAD_CHECKSUM_EN
module rom_load_sequencer #(
  parameter int GAP_CYCLES = 1,
  parameter int MAX_SIZE   = 28688,
  parameter int TIMEOUT    = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       src0_req,
  input  logic [7:0] src0_data,
  input  logic       src0_valid,
  output logic       src0_ready,
  input  logic       src1_req,
  input  logic [7:0] src1_data,
  input  logic       src1_valid,
  output logic       src1_ready,
  output logic       downloading,
  output logic [7:0] odata,
  output logic       odata_clk,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic       active_src
`ifdef LOAD_CHECKSUM_EN
  ,
  output logic [7:0] checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_HEADER, S_BODY, S_DONE, S_ERROR
  } state_t;

  state_t      state;
  logic [31:0] pace;       // cycles left before the next byte may be accepted
  logic [31:0] tcnt;       // consecutive starved cycles
  logic [23:0] cnt;        // bytes accepted so far
  logic [23:0] total;      // image length taken from the header
  logic [7:0]  prg, chr;
  logic        trn;
  logic        last_pend;  // final byte strobed; DONE follows next cycle

  logic        busy, xfer, sel_valid, magic_bad;
  logic [7:0]  sel_data;
  logic [23:0] cnt_nx, total_w;

  // Ready depends only on registered state. The pacing counter also covers the
  // strobe cycle, so a byte is never accepted while its predecessor is still
  // being presented to the loader.
  assign busy       = (state == S_HEADER || state == S_BODY) && (pace == 32'd0) && !last_pend;
  assign src0_ready = busy && !active_src;
  assign src1_ready = busy && active_src;

  assign sel_valid  = active_src ? src1_valid : src0_valid;
  assign sel_data   = active_src ? src1_data  : src0_data;
  assign xfer       = busy && sel_valid;
  assign cnt_nx     = cnt + 24'd1;

  // The largest possible value is about 6.3M, so 24 bits cannot overflow.
  assign total_w = 24'd16 + {2'b0, prg, 14'b0} + {3'b0, chr, 13'b0} + (trn ? 24'd512 : 24'd0);

  always_comb begin
    magic_bad = 1'b0;
    if (state == S_HEADER && cnt < 24'd4) begin
      case (cnt[1:0])
        2'd0:    magic_bad = (sel_data != 8'h4E);
        2'd1:    magic_bad = (sel_data != 8'h45);
        2'd2:    magic_bad = (sel_data != 8'h53);
        default: magic_bad = (sel_data != 8'h1A);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pace        <= '0;
      tcnt        <= '0;
      cnt         <= '0;
      total       <= '0;
      prg         <= '0;
      chr         <= '0;
      trn         <= 1'b0;
      last_pend   <= 1'b0;
      downloading <= 1'b0;
      odata       <= '0;
      odata_clk   <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= '0;
      active_src  <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      odata_clk <= 1'b0;
      if (pace != 32'd0) pace <= pace - 32'd1;

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= 2'd0;
            cnt       <= '0;
            tcnt      <= '0;
            last_pend <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
            checksum  <= '0;
`endif
            state     <= S_GRANT;
          end
        end

        S_GRANT: begin
          if (src1_req || src0_req) begin
            active_src  <= src1_req;
            downloading <= 1'b1;
            state       <= S_HEADER;
          end else begin
            error    <= 1'b1;
            err_code <= 2'd0;
            state    <= S_ERROR;
          end
        end

        S_HEADER, S_BODY: begin
          if (last_pend) begin
            last_pend   <= 1'b0;
            downloading <= 1'b0;
            done        <= 1'b1;
            state       <= S_DONE;
          end else if (xfer) begin
            tcnt <= '0;
            if (magic_bad) begin
              // Bad magic bytes are dropped, not forwarded.
              error       <= 1'b1;
              err_code    <= 2'd1;
              downloading <= 1'b0;
              state       <= S_ERROR;
            end else begin
              odata     <= sel_data;
              odata_clk <= 1'b1;
              pace      <= 32'(GAP_CYCLES);
              cnt       <= cnt_nx;
`ifdef LOAD_CHECKSUM_EN
              checksum  <= checksum + sel_data;
`endif
              if (state == S_HEADER) begin
                if (cnt == 24'd4) prg <= sel_data;
                if (cnt == 24'd5) chr <= sel_data;
                if (cnt == 24'd6) trn <= sel_data[2];
                if (cnt == 24'd15) begin
                  total <= total_w;
                  if (total_w > 24'(MAX_SIZE)) begin
                    // Byte 15 is still strobed this cycle; the error shows alongside it.
                    error       <= 1'b1;
                    err_code    <= 2'd2;
                    downloading <= 1'b0;
                    state       <= S_ERROR;
                  end else begin
                    state <= S_BODY;
                    // A header-only image is complete right here.
                    if (total_w == 24'd16) last_pend <= 1'b1;
                  end
                end
              end else if (cnt_nx == total) begin
                last_pend <= 1'b1;
              end
            end
          end else if (busy) begin
            if (tcnt == 32'(TIMEOUT - 1)) begin
              error       <= 1'b1;
              err_code    <= 2'd3;
              downloading <= 1'b0;
              state       <= S_ERROR;
            end else begin
              tcnt <= tcnt + 32'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Testbench for rom_load_sequencer.
// The first part is a table of directed loads. Each table entry sets the
// source requests, the header fields and the stall behaviour, and holds the
// expected outcome. The second part is a set of randomized loads. Their
// expected outcome comes from an image-level reference model.
// A hand-written sequence then covers a reset in the middle of the body.
module tb_rom_load_sequencer;
  localparam int GAP = 1;
  localparam int MAXS = 28688;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       src0_req = 1'b0, src0_valid = 1'b0, src0_ready;
  logic [7:0] src0_data = 8'h00;
  logic       src1_req = 1'b0, src1_valid = 1'b0, src1_ready;
  logic [7:0] src1_data = 8'h00;
  logic       downloading, odata_clk, done, error, active_src;
  logic [7:0] odata;
  logic [1:0] err_code;
`ifdef LOAD_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  rom_load_sequencer #(.GAP_CYCLES(GAP), .MAX_SIZE(MAXS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src0_req(src0_req), .src0_data(src0_data), .src0_valid(src0_valid), .src0_ready(src0_ready),
    .src1_req(src1_req), .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(src1_ready),
    .downloading(downloading), .odata(odata), .odata_clk(odata_clk),
    .done(done), .error(error), .err_code(err_code), .active_src(active_src)
`ifdef LOAD_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic       r0, r1;
    int         p, c, t;
    int         bad_idx;
    logic [7:0] bad_val;
    int         pct, stall;
    logic       exp_act;
    int         exp_n;
    logic       exp_done;
    logic [1:0] exp_code;
    logic       use_model;
  } vec_t;

  function automatic vec_t mkv(input logic r0, r1, input int p, c, t, bi, input logic [7:0] bv,
                               input int pct, st, input logic ea, input int en,
                               input logic ed, input logic [1:0] ec);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.p = p; v.c = c; v.t = t; v.bad_idx = bi; v.bad_val = bv;
    v.pct = pct; v.stall = st; v.exp_act = ea; v.exp_n = en; v.exp_done = ed;
    v.exp_code = ec; v.use_model = 1'b0;
    return v;
  endfunction

  // ---------------- source models ----------------
  logic [7:0] img0[];
  logic [7:0] img1[];
  int idx0 = 0, idx1 = 0;
  bit hs0 = 1'b0, hs1 = 1'b0;
  int pct = 100, stall = -1;

  initial begin
    forever begin
      @(negedge clk);
      if (hs0) idx0++;
      if (hs1) idx1++;
      if (idx0 < img0.size() && (stall < 0 || idx0 < stall) && int'($urandom_range(99)) < pct) begin
        src0_valid = 1'b1; src0_data = img0[idx0];
      end else begin
        src0_valid = 1'b0; src0_data = 8'($urandom);
      end
      if (idx1 < img1.size() && (stall < 0 || idx1 < stall) && int'($urandom_range(99)) < pct) begin
        src1_valid = 1'b1; src1_data = img1[idx1];
      end else begin
        src1_valid = 1'b0; src1_data = 8'($urandom);
      end
      #1;
      hs0 = src0_valid && src0_ready && !reset;
      hs1 = src1_valid && src1_ready && !reset;
    end
  end

  // ---------------- output monitor ----------------
  logic [7:0] expb[];
  bit   mon_en = 1'b0, exact_gap = 1'b0, g_act = 1'b0, prev_gr = 1'b0;
  int   nstr = 0, datbad = 0, gap_bad = 0, ready_bad = 0, dl_bad = 0;
  int   last_cyc = -1, rise_cyc = -1, g_n = 0;
  logic g_done = 1'b0;
  logic [1:0] g_code = 2'd0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (g_act ? src1_ready : src0_ready) begin
          if (!prev_gr) rise_cyc = cyc;
          prev_gr = 1'b1;
        end else prev_gr = 1'b0;
        if ((g_act && src0_ready) || (!g_act && src1_ready)) ready_bad++;
        if (odata_clk) begin
          if (nstr >= expb.size() || odata != expb[nstr]) datbad++;
          if (nstr + 1 < g_n && !downloading) dl_bad++;
          if (nstr > 0) begin
            if (exact_gap ? (cyc - last_cyc != GAP + 1) : (cyc - last_cyc < GAP + 1)) gap_bad++;
          end
          last_cyc = cyc;
          nstr++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // ---------------- reference model ----------------
  // Outcome of a load, derived from the image alone: how many bytes reach the
  // loader and how the load ends.
  function automatic void ref_model(input logic [7:0] im[], output int n,
                                    output logic dn, output logic [1:0] code);
    logic [7:0] mg[4];
    int tot;
    mg = '{8'h4E, 8'h45, 8'h53, 8'h1A};
    n = 0; dn = 1'b0; code = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (im[i] != mg[i]) begin n = i; code = 2'd1; return; end
    end
    tot = 16 + int'(im[4]) * 16384 + int'(im[5]) * 8192 + (im[6][2] ? 512 : 0);
    if (tot > MAXS) begin n = 16; code = 2'd2; end
    else begin n = tot; dn = 1'b1; end
  endfunction

  task automatic build(output logic [7:0] im[], input int p, c, t, bi, input logic [7:0] bv);
    int tot, len;
    tot = 16 + p * 16384 + c * 8192 + t * 512;
    len = (tot <= MAXS) ? tot : 64;
    im = new[len];
    foreach (im[i]) im[i] = 8'($urandom);
    im[0] = 8'h4E; im[1] = 8'h45; im[2] = 8'h53; im[3] = 8'h1A;
    im[4] = 8'(p); im[5] = 8'(c);
    im[6] = (8'($urandom) & 8'hFB) | ((t != 0) ? 8'h04 : 8'h00);
    if (bi >= 0) im[bi] = bv;
  endtask

  task automatic begin_load(input vec_t v);
    @(posedge clk);
    if (v.r1) build(img1, v.p, v.c, v.t, v.bad_idx, v.bad_val);
    else img1 = new[0];
    if (v.r0 && !v.r1) build(img0, v.p, v.c, v.t, v.bad_idx, v.bad_val);
    else if (v.r0) begin
      img0 = new[600];
      foreach (img0[i]) img0[i] = 8'($urandom);
    end else img0 = new[0];
    idx0 = 0; idx1 = 0; hs0 = 1'b0; hs1 = 1'b0;
    pct = v.pct; stall = v.stall;
    expb = v.r1 ? img1 : img0;
    if (v.use_model) begin
      ref_model(expb, g_n, g_done, g_code);
      g_act = v.r1;
    end else begin
      g_n = v.exp_n; g_done = v.exp_done; g_code = v.exp_code; g_act = v.exp_act;
    end
    exact_gap = (v.pct == 100);
    nstr = 0; datbad = 0; gap_bad = 0; ready_bad = 0; dl_bad = 0;
    last_cyc = -1; rise_cyc = -1; prev_gr = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    src0_req = v.r0; src1_req = v.r1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_load(input vec_t v, input string tag);
    int k, end_cyc, sum;
    k = 0;
    while (!(done || error) && k < 60000) begin tick(); k++; end
    end_cyc = cyc;
    chk({tag, " finished"}, done || error, 1);
    chk({tag, " done"}, done, g_done);
    chk({tag, " error"}, error, !g_done);
    chk({tag, " err_code"}, err_code, g_code);
    chk({tag, " downloading"}, downloading, 0);
    if (v.r0 || v.r1) chk({tag, " active_src"}, active_src, g_act);
    if (g_done) chk({tag, " done latency"}, end_cyc - last_cyc, 1);
    if (!g_done && g_code == 2'd3) chk({tag, " timeout latency"}, end_cyc - rise_cyc, TO);
    repeat (4) tick();
    mon_en = 1'b0;
    chk({tag, " strobes"}, nstr, g_n);
    chk({tag, " data mismatches"}, datbad, 0);
    chk({tag, " pacing"}, gap_bad, 0);
    chk({tag, " wrong-source ready"}, ready_bad, 0);
    chk({tag, " downloading low"}, dl_bad, 0);
`ifdef LOAD_CHECKSUM_EN
    sum = 0;
    for (int i = 0; i < g_n && i < expb.size(); i++) sum += int'(expb[i]);
    chk({tag, " checksum"}, checksum, sum % 256);
`else
    sum = 0;
`endif
    src0_req = 1'b0; src1_req = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  vec_t tv[10];
  vec_t v;

  initial begin
    tv[0] = mkv(1, 0, 1, 1, 0, -1, 8'h00, 100, -1, 0, 24592, 1, 2'd0); // full src0 load
    tv[1] = mkv(1, 1, 0, 0, 1, -1, 8'h00, 100, -1, 1, 528,   1, 2'd0); // src1 priority
    tv[2] = mkv(1, 0, 0, 0, 0,  2, 8'h54, 100, -1, 0, 2,     0, 2'd1); // bad magic byte 2
    tv[3] = mkv(0, 1, 2, 1, 0, -1, 8'h00, 100, -1, 1, 16,    0, 2'd2); // oversize
    tv[4] = mkv(1, 0, 0, 0, 0, -1, 8'h00, 100, -1, 0, 16,    1, 2'd0); // header-only image
    tv[5] = mkv(1, 0, 0, 0, 1, -1, 8'h00, 100, 20, 0, 20,    0, 2'd3); // stall -> timeout
    tv[6] = mkv(1, 0, 0, 0, 1, -1, 8'h00, 100, -1, 0, 528,   1, 2'd0); // clean reload
    tv[7] = mkv(0, 0, 0, 0, 0, -1, 8'h00, 100, -1, 0, 0,     0, 2'd0); // no source
    tv[8] = mkv(0, 1, 0, 0, 0,  0, 8'h00, 100, -1, 1, 0,     0, 2'd1); // bad magic byte 0
    tv[9] = mkv(1, 0, 0, 4, 0, -1, 8'h00, 100, -1, 0, 16,    0, 2'd2); // C=4 oversize

    // reset state
    repeat (3) tick();
    chk("rst odata", odata, 0);
    chk("rst odata_clk", odata_clk, 0);
    chk("rst downloading", downloading, 0);
    chk("rst done", done, 0);
    chk("rst error", error, 0);
    chk("rst err_code", err_code, 0);
    chk("rst active_src", active_src, 0);
    chk("rst ready", {src1_ready, src0_ready}, 0);
`ifdef LOAD_CHECKSUM_EN
    chk("rst checksum", checksum, 0);
`endif
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      begin_load(tv[i]);
      finish_load(tv[i], $sformatf("vec%0d", i));
    end

    // randomized loads, judged by the reference model
    for (int i = 0; i < 6; i++) begin
      int r;
      r = int'($urandom_range(2));
      v = mkv(r != 1, r != 0, 0, 0, int'($urandom_range(1)), -1, 8'h00,
              int'($urandom_range(60, 100)), -1, 0, 0, 0, 2'd0);
      if ($urandom_range(3) == 0) begin
        v.bad_idx = int'($urandom_range(3)); v.bad_val = 8'($urandom);
      end
      if ($urandom_range(3) == 0) begin
        v.p = int'($urandom_range(2, 255)); v.c = int'($urandom_range(255));
      end
      v.use_model = 1'b1;
      begin_load(v);
      finish_load(v, $sformatf("rand%0d", i));
    end

    // reset in the middle of the body, with a start pulse that must be ignored
    begin
      int k, sum;
      v = mkv(0, 1, 0, 1, 0, -1, 8'h00, 100, -1, 1, 8208, 1, 2'd0);
      begin_load(v);
      k = 0;
      while (nstr < 1000 && k < 5000) begin tick(); k++; end
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (nstr < 5000 && k < 20000) begin tick(); k++; end
      chk("mid reached 5000", nstr, 5000);
      chk("mid data mismatches", datbad, 0);
      chk("mid downloading", downloading, 1);
`ifdef LOAD_CHECKSUM_EN
      sum = 0;
      for (int i = 0; i < 5000; i++) sum += int'(expb[i]);
      chk("mid checksum", checksum, sum % 256);
`else
      sum = 0;
`endif
      reset = 1'b1;
      tick();
      chk("mid rst odata", odata, 0);
      chk("mid rst odata_clk", odata_clk, 0);
      chk("mid rst downloading", downloading, 0);
      chk("mid rst done/error", {done, error, err_code}, 0);
      chk("mid rst active_src", active_src, 0);
      chk("mid rst ready", {src1_ready, src0_ready}, 0);
`ifdef LOAD_CHECKSUM_EN
      chk("mid rst checksum", checksum, 0);
`endif
      reset = 1'b0;
      repeat (40) tick();
      mon_en = 1'b0;
      chk("mid no further strobes", nstr, 5000);
      chk("mid idle downloading", downloading, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
